// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, coefficient type and FSM states for the encrypt path
package kyber_pkg;
    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int KYBER_R_WIDTH = 12;
    localparam int KYBER_K = 2;
    typedef logic [KYBER_R_WIDTH-1:0] coeff_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    function automatic int n_beats(input int lanes);
        return KYBER_N / lanes;
    endfunction
endpackage

// File: rtl/mod_add_q.sv
// mod_add_q: (a + b) mod q for a, b already reduced into [0, q-1]
module mod_add_q
    import kyber_pkg::*;
(
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t y
);
    logic [12:0] s, d;
    assign s = {1'b0, a} + {1'b0, b};
    assign d = s - 13'(KYBER_Q);
    assign y = (s >= 13'(KYBER_Q)) ? d[11:0] : s[11:0];
endmodule

// File: rtl/msg_poly_add.sv
// msg_poly_add: adds a latched message polynomial to a streamed v polynomial mod q,
// LANES coefficients per beat, single output register with pass-through backpressure.
module msg_poly_add
    import kyber_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [KYBER_N*KYBER_R_WIDTH*KYBER_K-1:0]    poly_msg,
    input  logic                                        v_valid,
    output logic                                        v_ready,
    input  logic [LANES*KYBER_R_WIDTH-1:0]              v_coeff,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [LANES*KYBER_R_WIDTH-1:0]              out_coeff,
    output logic                                        busy,
    output logic                                        done
);
    localparam int BEATS = n_beats(LANES);
    localparam int CW = $clog2(BEATS);
    localparam int W = LANES * KYBER_R_WIDTH;
    localparam int MW = KYBER_N * KYBER_R_WIDTH;
    state_t state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] m_reg;
    logic [W-1:0] m_beat, sum;
    logic v_fire, o_fire, last, unused_msg;
    assign v_ready = (state == RUN) && (!out_valid || out_ready);
    assign v_fire = v_valid && v_ready;
    assign o_fire = out_valid && out_ready;
    assign last = cnt == CW'(BEATS - 1);
    assign m_beat = m_reg[cnt*W +: W];
    assign busy = state != IDLE;
    // Only the last v beat can be in the output register while draining.
    assign done = (state == DRAIN) && o_fire;
    assign unused_msg = ^poly_msg[KYBER_N*KYBER_R_WIDTH*KYBER_K-1:MW];
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_add_q u_add (
            .a(v_coeff[i*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
            .b(m_beat[i*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
            .y(sum[i*KYBER_R_WIDTH +: KYBER_R_WIDTH])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            m_reg <= '0;
            out_valid <= 1'b0;
            out_coeff <= '0;
        end else begin
            out_valid <= v_fire || (out_valid && !out_ready);
            if (v_fire) out_coeff <= sum;
            case (state)
                IDLE: if (start) begin
                    m_reg <= poly_msg[MW-1:0];
                    cnt <= '0;
                    state <= RUN;
                end
                RUN: if (v_fire) begin
                    cnt <= last ? cnt : cnt + 1'b1;
                    state <= last ? DRAIN : RUN;
                end
                DRAIN: if (o_fire) begin
                    cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_poly_add.sv
// tb_msg_poly_add: directed vectors, scoreboard queue filled at v acceptance, popped by an output monitor
module tb_msg_poly_add;
    import kyber_pkg::*;
    localparam int L = 4;
    localparam int B = KYBER_N / L;
    localparam int W = L * 12;
    localparam int MW = KYBER_N * 12 * KYBER_K;
    logic clk = 0, rst = 1, start = 0, v_valid = 0, out_ready = 1;
    logic v_ready, out_valid, busy, done;
    logic [MW-1:0] poly_msg = '0;
    logic [W-1:0] v_coeff = '0, out_coeff, held, e_push;
    int vecs = 0, errs = 0, ib = 0, ob = 0, ndone = 0;
    bit rand_rdy = 0, hold = 0;
    int vbuf[KYBER_N], mbuf[KYBER_N], ebuf[KYBER_N];
    logic [W-1:0] sb[$];

    msg_poly_add #(.LANES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .poly_msg(poly_msg),
        .v_valid(v_valid), .v_ready(v_ready), .v_coeff(v_coeff),
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Expected result for each accepted v beat, taken from the hand-filled table.
    always @(negedge clk) begin
        if (!rst && v_valid && v_ready) begin
            if (ib >= B) begin
                vecs++; errs++;
                $display("FAIL v_overrun: got beat %0d want at most %0d", ib, B - 1);
            end else begin
                for (int j = 0; j < L; j++) e_push[j*12 +: 12] = 12'(ebuf[ib*L + j]);
                sb.push_back(e_push);
            end
            ib++;
        end
    end

    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (hold) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_coeff), 64'(held));
            end
            hold = out_valid && !out_ready;
            held = out_coeff;
            if (done) ndone++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL extra_beat: got %0h want none", out_coeff);
                end else chk($sformatf("beat%0d", ob), 64'(out_coeff), 64'(sb.pop_front()));
                chk("done_at_last", 64'(done), 64'(ob == B - 1));
                ob++;
            end else if (done) chk("done_spurious", 64'(done), 64'd0);
        end
    end

    task automatic do_start();
        for (int i = 0; i < MW / 32; i++) poly_msg[i*32 +: 32] = $urandom;
        for (int i = 0; i < KYBER_N; i++) poly_msg[i*12 +: 12] = 12'(mbuf[i]);
        ib = 0; ob = 0; ndone = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic send(input int gap_pct, input int abort_at, input int spur_at);
        bit acc;
        int t;
        for (int b = 0; b < B; b++) begin
            if (b == abort_at) begin
                v_valid = 0;
                return;
            end
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                v_valid = 0;
                @(posedge clk); #1;
            end
            v_valid = 1;
            for (int j = 0; j < L; j++) v_coeff[j*12 +: 12] = 12'(vbuf[b*L + j]);
            t = 0;
            do begin
                start = (b == spur_at);
                if (start) poly_msg = ~poly_msg;
                @(negedge clk) acc = v_ready;
                @(posedge clk); #1 start = 0;
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                vecs++; errs++;
                $display("FAIL v_accept_timeout: got no v_ready want beat %0d accepted", b);
                v_valid = 0;
                return;
            end
        end
        v_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", 64'(t < 2000), 64'd1);
        chk("beat_count", 64'(ob), 64'(B));
        chk("one_done", 64'(ndone), 64'd1);
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < KYBER_N; i++) begin
            case (mode)
                0: begin mbuf[i] = 0; vbuf[i] = i; ebuf[i] = i; end
                1: begin mbuf[i] = 1665; vbuf[i] = 3328; ebuf[i] = 1664; end
                2: begin mbuf[i] = 1665; vbuf[i] = 1664; ebuf[i] = 0; end
                3: begin mbuf[i] = 3328; vbuf[i] = 3328; ebuf[i] = 3327; end
                4: begin mbuf[i] = (i % 2) ? 1665 : 0; vbuf[i] = 1664; ebuf[i] = (i % 2) ? 0 : 1664; end
                default: begin
                    mbuf[i] = $urandom_range(0, 1) ? 1665 : 0;
                    vbuf[i] = $urandom_range(0, KYBER_Q - 1);
                    ebuf[i] = (vbuf[i] + mbuf[i]) % KYBER_Q;
                end
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_coeff", 64'(out_coeff), 64'd0);
        chk("rst_v_ready", 64'(v_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 0;
        for (int m = 0; m < 5; m++) begin
            fill(m);
            do_start();
            send(0, -1, -1);
            drain();
        end
        rand_rdy = 1;
        fill(5);
        do_start();
        send(30, -1, -1);
        drain();
        rand_rdy = 0;
        fill(5);
        do_start();
        send(0, 20, -1);
        rst = 1;
        @(posedge clk); #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_v_ready", 64'(v_ready), 64'd0);
        rst = 0;
        sb.delete();
        fill(5);
        do_start();
        send(0, -1, -1);
        drain();
        rand_rdy = 1;
        fill(4);
        do_start();
        send(0, -1, 10);
        drain();
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
